pulse_level_gen: RTL and testbench
==================================

# pulse_level_gen

Converts single-cycle event pulses into fixed-width high levels with a guaranteed low gap between them. Each level's falling edge is clean and detectable, so downstream falling-edge detectors in the interconnect utilities see exactly one falling edge per accepted event. Sits in the interconnect utility library between event sources (handshake-complete strobes, arbiter grants) and level-sensitive or edge-sampling consumers. Optionally queues events that arrive while a level is in progress.

## Interface
- WIDTH, 4: cycles Level stays high per event; legal range ≥1.
- GAP, 1: minimum cycles Level stays low between consecutive levels; legal range ≥1.
- QDEPTH, 3: maximum queued events (used only with PULSE_QUEUE_EN); legal range ≥1.
- ACLK  input  1  clock; all logic on the rising edge.
- ARESETN  input  1  asynchronous, active-low reset.
- Trigger  input  1  event pulse; each high cycle is one event.
- Level  output  1  stretched level output, registered.
- Done  output  1  one-cycle pulse in the cycle Level first reads low after a level.
- Busy  output  1  high whenever state ≠ IDLE.
- Pending  output  $clog2(QDEPTH+1)  queued event count; constant 0 without the macro.
- Overflow  output  1  one-cycle pulse when an event is dropped.

## Operation
- Reset values: Level=0, Done=0, Busy=0, Pending=0, Overflow=0, state=IDLE, counters=0.
- FSM states:
  - IDLE: Trigger=1 → HIGH, load cnt=WIDTH-1.
  - HIGH: Level=1. Decrement cnt. At cnt==0 → GAP, load cnt=GAP-1.
  - GAP: Level=0. At cnt==0: if Pending>0 → HIGH, decrement Pending, load WIDTH-1; otherwise → IDLE.
- Done fires on the HIGH→GAP transition and is registered alongside Level=0.
- Trigger outside IDLE, macro enabled:
  - Pending<QDEPTH: Pending+1.
  - Pending==QDEPTH: event dropped, Overflow=1 for one cycle.
- Trigger outside IDLE, macro disabled: event dropped, Overflow=1 for one cycle.
- Trigger in the GAP cycle where cnt==0 with Pending==0: the event is queued (macro on), so the next level starts immediately. It is not lost. Without the macro it is dropped.
- Simultaneous Trigger and Pending decrement (GAP→HIGH): Pending stays unchanged. Overflow is evaluated against the pre-decrement value, so a full queue still drops the event.
- Counter width: $clog2(max(WIDTH,GAP)). Use 1 bit when the maximum is 1. No wrap is possible.
- Reset asserted mid-level: Level drops asynchronously to 0, the queue clears, and Done is not emitted.

## Timing
- Trigger high at edge t (IDLE): Level=1 over cycles t+1 … t+WIDTH; Level=0 at t+WIDTH+1.
- Done=1 during cycle t+WIDTH+1 only.
- Busy=1 from t+1 until the last GAP cycle inclusive. Back in IDLE at t+WIDTH+GAP+1.
- Queued event: the next rising edge of Level comes exactly GAP low cycles after the falling edge.
- Earliest re-trigger from IDLE: Trigger may be high at the edge ending the last GAP cycle. It is accepted as a queued event and produces an identical spacing.
- Overflow and Done are registered and never held more than one cycle.
- Event-to-Level latency: 1 cycle.

## Configuration
- PULSE_QUEUE_EN defined:
  - The Pending counter is built and up to QDEPTH events are buffered during Busy.
  - Overflow fires only when the queue is full.
- PULSE_QUEUE_EN undefined:
  - Pending is tied to 0 and the queue logic is removed.
  - Every Trigger while Busy=1 is dropped and raises Overflow.

## Test plan
- Reset → Level/Done/Busy/Overflow=0, Pending=0. Assert ARESETN low mid-HIGH → Level=0 immediately, Pending=0, no Done.
- WIDTH=4, GAP=1, single Trigger at cycle 10 → Level=1 cycles 11–14, Done=1 cycle 15, Busy=0 from cycle 16.
- Macro on, QDEPTH=3, Trigger held high 5 cycles from IDLE → 4 levels produced (1 immediate + 3 queued). Overflow=1 exactly once, on the fifth event. Each level is 4 high / 1 low.
- Macro off, same stimulus → one level only. Overflow pulses on cycles 2–5 of Trigger. Pending stays 0.
- Macro on, Trigger in the final GAP cycle with Pending=0 → Level rises the next cycle, Busy never drops, Done count=2.
- WIDTH=1, GAP=1, Trigger every other cycle for 8 events → Level toggles 1/0 each cycle, 8 Done pulses, no Overflow, Pending ≤1.

Source files
------------

// File: rtl/pulse_level_gen.sv
// pulse_level_gen: stretches single-cycle event pulses into WIDTH-cycle high
// levels separated by at least GAP low cycles, with one Done pulse per level.
// Optional event queue enabled by defining PULSE_QUEUE_EN; when undefined,
// Pending reads 0 and every Trigger seen while busy is dropped with Overflow.
module pulse_level_gen #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned GAP    = 1,
  parameter int unsigned QDEPTH = 3
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          Trigger,
  output logic                          Level,
  output logic                          Done,
  output logic                          Busy,
  output logic [$clog2(QDEPTH+1)-1:0]   Pending,
  output logic                          Overflow
);

  localparam int unsigned MAXWG = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int unsigned CW    = (MAXWG > 1) ? $clog2(MAXWG) : 1;
  localparam int unsigned PW    = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, done_q, busy_q, ovf_q;
  logic            done_d;
  logic            busy_trig;
  logic            gap_end;
  logic            restart;
  logic            drop;

  // Events that arrive while a level or gap is in progress
  assign busy_trig = (state_q != S_IDLE) && Trigger;
  // Final low cycle of the gap, where the next level may start
  assign gap_end   = (state_q == S_GAP) && (cnt_q == '0);

`ifdef PULSE_QUEUE_EN
  logic [PW-1:0] pend_q, pend_d;
  logic          q_full;
  logic          push;

  // Queue bookkeeping; a trigger in the last gap cycle is pushed and popped at once
  always_comb begin
    pend_d  = pend_q;
    q_full  = (pend_q == PW'(QDEPTH));
    push    = busy_trig && !q_full;
    drop    = busy_trig && q_full;
    restart = gap_end && ((pend_q != '0) || Trigger);
    if (push && !restart) begin
      pend_d = pend_q + PW'(1);
    end else if (restart && !push) begin
      pend_d = pend_q - PW'(1);
    end
  end

  // Pending event counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign Pending = pend_q;
`else
  // No queue: anything arriving while busy is lost
  always_comb begin
    restart = 1'b0;
    drop    = busy_trig;
  end

  assign Pending = PW'(0);
`endif

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Trigger) begin
          state_d = S_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP - 1);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (gap_end) begin
          if (restart) begin
            state_d = S_HIGH;
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == S_HIGH);
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
      ovf_q   <= drop;
    end
  end

  assign Level    = level_q;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Directed bench for pulse_level_gen; expectations follow PULSE_QUEUE_EN.
module tb_pulse_level_gen;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       trig, trig1;
  logic       lvl, done, busy, ovf;
  logic [1:0] pend;
  logic       lvl1, done1, busy1, ovf1;
  logic [1:0] pend1;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  pulse_level_gen #(.WIDTH(4), .GAP(1), .QDEPTH(3)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .Trigger(trig),
    .Level(lvl), .Done(done), .Busy(busy), .Pending(pend), .Overflow(ovf)
  );

  pulse_level_gen #(.WIDTH(1), .GAP(1), .QDEPTH(3)) dut1 (
    .ACLK(ACLK), .ARESETN(ARESETN), .Trigger(trig1),
    .Level(lvl1), .Done(done1), .Busy(busy1), .Pending(pend1), .Overflow(ovf1)
  );

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    trig    = 1'b0;
    trig1   = 1'b0;
    #12;
    if ({lvl, done, busy, ovf} !== 4'b0000) begin
      $display("FAIL reset_flags got %b exp 0000", {lvl, done, busy, ovf}); errors++;
    end
    checks++;
    if (pend !== 2'd0) begin
      $display("FAIL reset_pending got %0d exp 0", pend); errors++;
    end
    checks++;
    if ({lvl1, done1, busy1, ovf1, pend1} !== 6'b0) begin
      $display("FAIL reset_dut1 got %b exp 000000", {lvl1, done1, busy1, ovf1, pend1}); errors++;
    end
    checks++;
    ARESETN = 1'b1;
    tick; tick;
  endtask

  task automatic test_single;
    logic el, ed, eb;
    tick;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      el = (k <= 4);
      ed = (k == 5);
      eb = (k <= 5);
      if ({lvl, done, busy, ovf} !== {el, ed, eb, 1'b0}) begin
        $display("FAIL single k=%0d got L/D/B/O=%b exp %b", k, {lvl, done, busy, ovf}, {el, ed, eb, 1'b0});
        errors++;
      end
      checks++;
      tick;
    end
  endtask

  task automatic test_burst;
    logic el, ed, eb, eo;
    logic [1:0] ep;
    int ovf_cnt = 0;
    trig = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick;
      trig = (k < 5);
`ifdef PULSE_QUEUE_EN
      el = (k <= 20) && (((k - 1) % 5) < 4);
      ed = (k >= 5) && (k <= 20) && ((k % 5) == 0);
      eb = (k <= 20);
      eo = (k == 5);
      if (k <= 4)       ep = 2'(k - 1);
      else if (k == 5)  ep = 2'd3;
      else if (k <= 10) ep = 2'd2;
      else if (k <= 15) ep = 2'd1;
      else              ep = 2'd0;
`else
      el = (k <= 4);
      ed = (k == 5);
      eb = (k <= 5);
      eo = (k >= 2) && (k <= 5);
      ep = 2'd0;
`endif
      if (ovf === 1'b1) ovf_cnt++;
      if ({lvl, done, busy, ovf} !== {el, ed, eb, eo}) begin
        $display("FAIL burst k=%0d got L/D/B/O=%b exp %b", k, {lvl, done, busy, ovf}, {el, ed, eb, eo});
        errors++;
      end
      checks++;
      if (pend !== ep) begin
        $display("FAIL burst_pending k=%0d got %0d exp %0d", k, pend, ep); errors++;
      end
      checks++;
    end
`ifdef PULSE_QUEUE_EN
    if (ovf_cnt != 1) begin
      $display("FAIL burst_overflow_count got %0d exp 1", ovf_cnt); errors++;
    end
`else
    if (ovf_cnt != 4) begin
      $display("FAIL burst_overflow_count got %0d exp 4", ovf_cnt); errors++;
    end
`endif
    checks++;
  endtask

  task automatic test_gap_retrigger;
    logic el, ed, eb, eo;
    int done_cnt = 0;
    trig = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick;
      trig = (k == 5);
`ifdef PULSE_QUEUE_EN
      el = ((k >= 1) && (k <= 4)) || ((k >= 6) && (k <= 9));
      ed = (k == 5) || (k == 10);
      eb = (k <= 10);
      eo = 1'b0;
`else
      el = (k <= 4);
      ed = (k == 5);
      eb = (k <= 5);
      eo = (k == 6);
`endif
      if (done === 1'b1) done_cnt++;
      if ({lvl, done, busy, ovf} !== {el, ed, eb, eo}) begin
        $display("FAIL gap_retrig k=%0d got L/D/B/O=%b exp %b", k, {lvl, done, busy, ovf}, {el, ed, eb, eo});
        errors++;
      end
      checks++;
      if (pend !== 2'd0) begin
        $display("FAIL gap_retrig_pending k=%0d got %0d exp 0", k, pend); errors++;
      end
      checks++;
    end
`ifdef PULSE_QUEUE_EN
    if (done_cnt != 2) begin
      $display("FAIL gap_retrig_done_count got %0d exp 2", done_cnt); errors++;
    end
`else
    if (done_cnt != 1) begin
      $display("FAIL gap_retrig_done_count got %0d exp 1", done_cnt); errors++;
    end
`endif
    checks++;
  endtask

  task automatic test_width1;
    logic el, ed, eb, eo;
    int done_cnt = 0;
    trig1 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick;
      trig1 = (k < 15) && ((k % 2) == 0);
`ifdef PULSE_QUEUE_EN
      el = (k <= 15) && ((k % 2) == 1);
      ed = (k <= 16) && ((k % 2) == 0);
      eb = (k <= 16);
      eo = 1'b0;
`else
      el = (k <= 13) && ((k % 4) == 1);
      ed = (k <= 14) && ((k % 4) == 2);
      eb = el || ed;
      eo = (k <= 15) && ((k % 4) == 3);
`endif
      if (done1 === 1'b1) done_cnt++;
      if ({lvl1, done1, busy1, ovf1} !== {el, ed, eb, eo}) begin
        $display("FAIL width1 k=%0d got L/D/B/O=%b exp %b", k, {lvl1, done1, busy1, ovf1}, {el, ed, eb, eo});
        errors++;
      end
      checks++;
      if (pend1 > 2'd1) begin
        $display("FAIL width1_pending k=%0d got %0d exp <=1", k, pend1); errors++;
      end
      checks++;
    end
`ifdef PULSE_QUEUE_EN
    if (done_cnt != 8) begin
      $display("FAIL width1_done_count got %0d exp 8", done_cnt); errors++;
    end
`else
    if (done_cnt != 4) begin
      $display("FAIL width1_done_count got %0d exp 4", done_cnt); errors++;
    end
`endif
    checks++;
  endtask

  task automatic test_reset_mid;
    logic [1:0] ep;
    trig = 1'b1;
    tick;
    tick;
    trig = 1'b0;
`ifdef PULSE_QUEUE_EN
    ep = 2'd1;
`else
    ep = 2'd0;
`endif
    if ({lvl, busy, pend} !== {1'b1, 1'b1, ep}) begin
      $display("FAIL pre_reset got L/B/P=%b exp %b", {lvl, busy, pend}, {1'b1, 1'b1, ep}); errors++;
    end
    checks++;
    #2;
    ARESETN = 1'b0;
    #1;
    if ({lvl, done, busy, ovf, pend} !== 6'b0) begin
      $display("FAIL async_reset got L/D/B/O/P=%b exp 000000", {lvl, done, busy, ovf, pend}); errors++;
    end
    checks++;
    tick;
    tick;
    #3;
    ARESETN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if ({lvl, done, busy, pend} !== 5'b0) begin
        $display("FAIL post_reset k=%0d got L/D/B/P=%b exp 00000", k, {lvl, done, busy, pend}); errors++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    tick; tick;
    test_burst;
    tick; tick;
    test_gap_retrigger;
    tick; tick;
    test_width1;
    tick; tick;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
